// File: rtl/r5p_bus_arb.sv
// Two-port (fetch / load-store) to one memory bus arbiter with wait-state grant lock and read-data return routing.
// Optional feature: define R5P_BUS_ARB_RR_EN for round-robin conflict resolution (default: load/store has fixed priority).
module r5p_bus_arb #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW/8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_adr,
    output logic [SW*8-1:0] if_rdt,
    output logic            if_ack,
    input  logic            ls_req,
    input  logic            ls_wen,
    input  logic [AW-1:0]   ls_adr,
    input  logic [SW-1:0]   ls_sel,
    input  logic [SW*8-1:0] ls_wdt,
    output logic [SW*8-1:0] ls_rdt,
    output logic            ls_ack,
    output logic            m_req,
    output logic            m_wen,
    output logic [AW-1:0]   m_adr,
    output logic [SW-1:0]   m_sel,
    output logic [SW*8-1:0] m_wdt,
    input  logic [SW*8-1:0] m_rdt,
    input  logic            m_ack
);

    typedef enum logic {ST_FREE, ST_LOCK} state_t;

    localparam logic P_IF = 1'b0;
    localparam logic P_LS = 1'b1;

    state_t state, state_nxt;
    logic   own, own_nxt;
    logic   lst;
    logic   rd_vld;
    logic   rd_own;
    logic   win;
    logic   conflict_win;
    logic   hs;

`ifdef R5P_BUS_ARB_RR_EN
    assign conflict_win = ~lst;
`else
    assign conflict_win = P_LS;
`endif

    always_comb begin
        win = P_LS;
        if (state == ST_LOCK)
            win = own;
        else if (if_req && ls_req)
            win = conflict_win;
        else if (if_req)
            win = P_IF;
    end

    // Gated by rst so nothing reaches the bus while reset is held.
    assign m_req = ~rst & ((win == P_LS) ? ls_req : if_req);
    assign hs    = m_req & m_ack;

    always_comb begin
        m_wen = 1'b0;
        m_adr = '0;
        m_sel = '0;
        m_wdt = '0;
        if (m_req) begin
            if (win == P_LS) begin
                m_wen = ls_wen;
                m_adr = ls_adr;
                m_sel = ls_sel;
                m_wdt = ls_wdt;
            end else begin
                m_adr = if_adr;
                m_sel = {SW{1'b1}};
            end
        end
    end

    assign if_ack = hs & (win == P_IF);
    assign ls_ack = hs & (win == P_LS);

    assign if_rdt = (rd_vld && rd_own == P_IF) ? m_rdt : '0;
    assign ls_rdt = (rd_vld && rd_own == P_LS) ? m_rdt : '0;

    always_comb begin
        state_nxt = state;
        own_nxt   = own;
        case (state)
            ST_FREE: begin
                if (m_req && !m_ack) begin
                    state_nxt = ST_LOCK;
                    own_nxt   = win;
                end
            end
            ST_LOCK: begin
                if (m_ack)
                    state_nxt = ST_FREE;
            end
            default: state_nxt = ST_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_FREE;
            own    <= P_LS;
            lst    <= P_IF;
            rd_vld <= 1'b0;
            rd_own <= P_IF;
        end else begin
            state  <= state_nxt;
            own    <= own_nxt;
            rd_vld <= hs;
            if (hs) begin
                rd_own <= win;
                lst    <= win;
            end
        end
    end

    // The locked owner must keep requesting until its transfer is acknowledged.
    a_lock_req_held: assert property (@(posedge clk) disable iff (rst)
        (state == ST_LOCK) |-> ((own == P_LS) ? ls_req : if_req));

    a_lst_tracks_win: assert property (@(posedge clk) disable iff (rst)
        hs |=> (lst == $past(win)));

endmodule

// File: doc/r5p_bus_arb.md
# r5p_bus_arb

Two-port-to-one bus arbiter that lets the r5p core's instruction fetch port and load/store port share a single memory bus. It sits between the core and a single-ported memory or interconnect. It locks the grant for a transfer held off by wait states. It also routes delayed read data back to the requester whose handshake produced it.

## Interface
Parameters:
- AW, 32, address width (all ports)
- DW, 32, data width (all ports)
- SW, DW/8, byte select width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  fetch request
- if_adr  input  AW  fetch address
- if_rdt  output  SW×8  fetch read data
- if_ack  output  1  fetch acknowledge
- ls_req  input  1  load/store request
- ls_wen  input  1  load/store write enable
- ls_adr  input  AW  load/store address
- ls_sel  input  SW  load/store byte select
- ls_wdt  input  SW×8  load/store write data
- ls_rdt  output  SW×8  load/store read data
- ls_ack  output  1  load/store acknowledge
- m_req  output  1  memory request
- m_wen  output  1  memory write enable
- m_adr  output  AW  memory address
- m_sel  output  SW  memory byte select
- m_wdt  output  SW×8  memory write data
- m_rdt  input  SW×8  memory read data
- m_ack  input  1  memory acknowledge

## Operation
- Protocol, all ports:
  - req&ack in the same cycle is one handshake.
  - Requester holds req and all request fields stable until ack.
  - Read data is valid exactly one cycle after the handshake.
- State registers:
  - lck: grant locked.
  - own: locked owner, IF or LS.
  - lst: last handshake winner.
  - rd_vld, rd_own: pending read-data owner.
- Unlocked (lck=0), winner selection:
  - Only one port requesting: that port wins.
  - Both requesting: LS wins (see Configuration).
  - m_* is driven from the winner.
  - Winner handshake with m_ack=0 → lck←1, own←winner.
- Locked (lck=1):
  - Winner is own regardless of the other port.
  - On m_ack: lck←0.
- The fetch port drives the memory bus as m_wen=0, m_sel=all ones, m_wdt=0.
- No requester: m_req=0 and all other m_* outputs 0.
- Acknowledge: x_ack = m_ack & m_req & (winner==x). A non-winner never sees ack.
- Read-data tracking:
  - On any handshake: rd_vld←1, rd_own←winner.
  - Otherwise rd_vld←0.
- Read-data routing:
  - x_rdt = m_rdt when rd_vld & rd_own==x, else 0.
  - Write handshakes also set rd_vld; the data is don't-care for the core, but routing is still enforced.
- lst←winner on every handshake.
- Reset values:
  - lck=0, own=LS, lst=IF, rd_vld=0, rd_own=IF.
  - Therefore at reset all x_ack=0, x_rdt=0, m_req=0.
- Reset asserted mid-transfer discards the lock and any pending read data.
  - The first cycle after reset deassertion arbitrates afresh.
- Requester dropping req while locked is a protocol violation.
  - The lock is kept until m_ack; an assertion flags the violation in simulation.

## Timing
- Request path is combinational: x_req → m_req, 0 cycles.
- Acknowledge path is combinational: m_ack → x_ack, 0 cycles.
- Read data appears on x_rdt in cycle N+1 for a handshake in cycle N.
- Back-to-back handshakes are supported with no bubble.
  - Alternating owners IF, LS, IF on consecutive cycles are legal.
  - Each port's rdt follows its own handshake by one cycle.
- Wait states: grant is held for any number of m_ack=0 cycles. No timeout.
- The handshake cycle and the next arbitration share no state except lst, so a new grant may begin the cycle after a locked transfer completes.

## Configuration
- R5P_BUS_ARB_RR_EN defined: round-robin arbitration.
  - On an unlocked conflict the winner is the port ≠ lst.
  - Guarantees each port a handshake within two transfers.
- Not defined: fixed priority, LS over IF.
  - lst is still maintained, but unused for selection.

## Test plan
- Reset with both req=1 → m_req=0, if_ack=ls_ack=0, if_rdt=ls_rdt=0 while rst=1. After release, first cycle grants LS.
- IF-only read:
  - Stimulus: if_adr=0x100, m_ack=1, m_rdt=0x00000013 in cycle N+1.
  - Response: if_ack=1 in cycle N; if_rdt=0x00000013 in N+1; ls_rdt=0.
- Locked wait state:
  - Stimulus: LS write, ls_adr=0x2000, ls_sel=0xF, ls_wdt=0xDEADBEEF, m_ack=0 for 3 cycles with if_req=1 throughout.
  - Response: m_adr=0x2000 on all 4 cycles; ls_ack=1 only on the 4th; if_ack=0 until the following cycle.
- Conflict, RR disabled: both req every cycle, m_ack=1 → LS granted every cycle, IF starved.
- Conflict, RR enabled: both req every cycle, m_ack=1 → grants alternate LS, IF, LS, IF.
  - Each rdt is routed one cycle later to the matching port.
- Reset mid-lock: LS locked with m_ack=0, pulse rst → lck cleared, rd_vld=0. Next cycle arbitrates afresh per configuration.
